// File: rtl/dfa_pkg.sv
// Shared types and constants for the DFA equivalence monitor.
package dfa_pkg;
  localparam int DFA_STATE_W = 2;
  localparam int DFA_SYM_W   = 1;

  typedef logic [DFA_STATE_W-1:0] state_t;
  typedef logic [DFA_SYM_W-1:0]   sym_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/dfa_core.sv
// One programmable DFA: next-state table, accept vector and current-state register.
module dfa_core
  import dfa_pkg::*;
#(
  parameter int STATE_W     = 2,
  parameter int SYM_W       = 1,
  parameter int START_STATE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart_i,
  input  logic               we_i,
  input  logic [STATE_W-1:0] cfg_state_i,
  input  logic [SYM_W-1:0]   cfg_sym_i,
  input  logic [STATE_W-1:0] cfg_next_i,
  input  logic               cfg_acc_i,
  input  logic               step_i,
  input  logic [SYM_W-1:0]   sym_i,
  output logic               acc_o
);
  localparam int NS = 2 ** STATE_W;
  localparam int NA = 2 ** SYM_W;
  localparam logic [STATE_W-1:0] START = STATE_W'(START_STATE);

  logic [NS-1:0][NA-1:0][STATE_W-1:0] nxt_q;
  logic [NS-1:0]                      acc_q;
  logic [STATE_W-1:0]                 state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (restart_i)   state_d = START;
    else if (step_i) state_d = nxt_q[state_q][sym_i];
  end

  // Table writes land at this edge; a step in the same cycle still sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      nxt_q   <= '0;
      acc_q   <= '0;
      state_q <= START;
    end else begin
      if (we_i) begin
        nxt_q[cfg_state_i][cfg_sym_i] <= cfg_next_i;
        acc_q[cfg_state_i]            <= cfg_acc_i;
      end
      state_q <= state_d;
    end
  end

  assign acc_o = acc_q[state_q];
endmodule

// File: rtl/dfa_equiv_monitor.sv
// Runs two programmable DFAs in lockstep and flags the first symbol count at which they disagree.
module dfa_equiv_monitor
  import dfa_pkg::*;
#(
  parameter int STATE_W     = 2,
  parameter int SYM_W       = 1,
  parameter int START_STATE = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [SYM_W-1:0]   cfg_sym,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic               cfg_acc,
  input  logic               restart,
  input  logic               in_valid,
  input  logic [SYM_W-1:0]   in_sym,
  output logic               in_ready,
  output logic               out_a,
  output logic               out_b,
  output logic               mismatch,
  output logic [CNT_W-1:0]   mismatch_idx,
  output logic [CNT_W-1:0]   sym_count
);
  logic             step;
  logic             we_a, we_b;
  logic [CNT_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic             mm_q, mm_d;

  assign in_ready = ~cfg_we & ~restart;
  assign step     = in_valid & in_ready;
  assign we_a     = cfg_we & (cfg_sel == SEL_A);
  assign we_b     = cfg_we & (cfg_sel == SEL_B);

  dfa_core #(.STATE_W(STATE_W), .SYM_W(SYM_W), .START_STATE(START_STATE)) u_dfa_a (
    .clk(clk), .reset(reset), .restart_i(restart), .we_i(we_a),
    .cfg_state_i(cfg_state), .cfg_sym_i(cfg_sym), .cfg_next_i(cfg_next), .cfg_acc_i(cfg_acc),
    .step_i(step), .sym_i(in_sym), .acc_o(out_a)
  );

  dfa_core #(.STATE_W(STATE_W), .SYM_W(SYM_W), .START_STATE(START_STATE)) u_dfa_b (
    .clk(clk), .reset(reset), .restart_i(restart), .we_i(we_b),
    .cfg_state_i(cfg_state), .cfg_sym_i(cfg_sym), .cfg_next_i(cfg_next), .cfg_acc_i(cfg_acc),
    .step_i(step), .sym_i(in_sym), .acc_o(out_b)
  );

  // The compare sees the count before this cycle's symbol, so idx is the length of the word read.
  always_comb begin
    cnt_d = cnt_q;
    mm_d  = mm_q;
    idx_d = idx_q;
    if (restart) begin
      cnt_d = '0;
      mm_d  = 1'b0;
      idx_d = '0;
    end else begin
      if (step && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      if (!mm_q && (out_a != out_b)) begin
        mm_d  = 1'b1;
        idx_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      mm_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      mm_q  <= mm_d;
      idx_q <= idx_d;
    end
  end

  assign sym_count    = cnt_q;
  assign mismatch     = mm_q;
  assign mismatch_idx = idx_q;
endmodule

// File: tb/tb_dfa_equiv_monitor.sv
// Directed bench for dfa_equiv_monitor with a per-cycle reference model and literal spot checks.
module tb_dfa_equiv_monitor;
  localparam int CW   = 3;
  localparam int CMAX = 7;
  localparam int START = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [1:0]    cfg_state = '0, cfg_next = '0;
  logic          cfg_sym = 1'b0, cfg_acc = 1'b0;
  logic          restart = 1'b0, in_valid = 1'b0, in_sym = 1'b0;
  logic          in_ready, out_a, out_b, mismatch;
  logic [CW-1:0] mismatch_idx, sym_count;

  int n_cmp = 0;
  int n_err = 0;

  dfa_equiv_monitor #(.STATE_W(2), .SYM_W(1), .START_STATE(START), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_state(cfg_state),
    .cfg_sym(cfg_sym), .cfg_next(cfg_next), .cfg_acc(cfg_acc), .restart(restart),
    .in_valid(in_valid), .in_sym(in_sym), .in_ready(in_ready), .out_a(out_a), .out_b(out_b),
    .mismatch(mismatch), .mismatch_idx(mismatch_idx), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  // Reference model: two machines as plain arrays, plus counter and flag rules.
  int m_nxt [2][4][2];
  int m_acc [2][4];
  int m_st  [2];
  int m_cnt, m_mm, m_idx;
  bit m_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int s = 0; s < 4; s++) begin
          m_acc[d][s] <= 0;
          for (int y = 0; y < 2; y++) m_nxt[d][s][y] <= 0;
        end
        m_st[d] <= START;
      end
      m_cnt <= 0; m_mm <= 0; m_idx <= 0; m_ok <= 1'b1;
    end else begin
      if (cfg_we) begin
        m_nxt[cfg_sel][cfg_state][cfg_sym] <= int'(cfg_next);
        m_acc[cfg_sel][cfg_state] <= int'(cfg_acc);
      end
      if (restart) begin
        m_st[0] <= START; m_st[1] <= START;
        m_cnt <= 0; m_mm <= 0; m_idx <= 0;
      end else begin
        if (in_valid && !cfg_we) begin
          m_st[0] <= m_nxt[0][m_st[0]][in_sym];
          m_st[1] <= m_nxt[1][m_st[1]][in_sym];
          if (m_cnt < CMAX) m_cnt <= m_cnt + 1;
        end
        if (m_mm == 0 && m_acc[0][m_st[0]] != m_acc[1][m_st[1]]) begin
          m_mm <= 1; m_idx <= m_cnt;
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok && !reset) begin
      cmp("in_ready", int'(in_ready), (cfg_we || restart) ? 0 : 1);
      cmp("out_a", int'(out_a), m_acc[0][m_st[0]]);
      cmp("out_b", int'(out_b), m_acc[1][m_st[1]]);
      cmp("mismatch", int'(mismatch), m_mm);
      cmp("mismatch_idx", int'(mismatch_idx), m_idx);
      cmp("sym_count", int'(sym_count), m_cnt);
    end
  end

  // Each task drives one cycle: set inputs, take the edge, return to idle 1ns later.
  task automatic clear_in();
    reset = 1'b0; cfg_we = 1'b0; restart = 1'b0; in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic wr(input logic sel, input int st, input int sym, input int nxt, input logic acc);
    cfg_we = 1'b1; cfg_sel = sel; cfg_state = 2'(st); cfg_sym = 1'(sym);
    cfg_next = 2'(nxt); cfg_acc = acc;
    tick();
  endtask

  task automatic feed(input logic s);
    in_valid = 1'b1; in_sym = s;
    tick();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk); #1;
    tick();
    cmp("rst_count", int'(sym_count), 0);
    cmp("rst_mismatch", int'(mismatch), 0);
    cmp("rst_out_a", int'(out_a), 0);

    // Two-state "last symbol was 1" recognizer in both machines.
    for (int d = 0; d < 2; d++) begin
      wr(d[0], 1, 1, 2, 1'b0); wr(d[0], 1, 0, 1, 1'b0);
      wr(d[0], 2, 1, 2, 1'b1); wr(d[0], 2, 0, 1, 1'b1);
    end
    do_restart();
    feed(1); feed(0); feed(1); feed(1); feed(0);
    tick();
    cmp("ident_count", int'(sym_count), 5);
    cmp("ident_mismatch", int'(mismatch), 0);
    cmp("ident_out_a", int'(out_a), 0);

    // Write and symbol together: symbol dropped.
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_state = 2'd1; cfg_sym = 1'b0; cfg_next = 2'd1;
    cfg_acc = 1'b0; in_valid = 1'b1; in_sym = 1'b1;
    #1 cmp("ready_low_cfg", int'(in_ready), 0);
    tick();
    cmp("drop_count", int'(sym_count), 5);
    restart = 1'b1; in_valid = 1'b1; in_sym = 1'b1;
    tick();
    cmp("restart_count", int'(sym_count), 0);

    // Same language, B uses s3 as its accepting state.
    wr(1'b1, 1, 1, 3, 1'b0); wr(1'b1, 1, 0, 1, 1'b0);
    wr(1'b1, 3, 1, 3, 1'b1); wr(1'b1, 3, 0, 1, 1'b1);
    do_restart();
    feed(1); feed(0); feed(1);
    tick();
    cmp("reenc_mismatch", int'(mismatch), 0);
    cmp("reenc_count", int'(sym_count), 3);
    cmp("reenc_out_b", int'(out_b), 1);

    // B falls into a rejecting sink on "10".
    wr(1'b1, 3, 0, 0, 1'b1); wr(1'b1, 0, 0, 0, 1'b0); wr(1'b1, 0, 1, 0, 1'b0);
    do_restart();
    feed(1); feed(0); feed(1);
    tick();
    cmp("sink_mismatch", int'(mismatch), 1);
    cmp("sink_idx", int'(mismatch_idx), 3);
    feed(1);
    tick();
    cmp("sink_idx_frozen", int'(mismatch_idx), 3);
    cmp("sink_keeps_count", int'(sym_count), 4);

    // Accept bit of the start state differs: empty word disagrees.
    wr(1'b1, 1, 0, 1, 1'b1);
    do_restart();
    tick();
    cmp("empty_mismatch", int'(mismatch), 1);
    cmp("empty_idx", int'(mismatch_idx), 0);

    // Saturation with matching machines, then reset mid-stream.
    wr(1'b1, 1, 0, 1, 1'b0);
    wr(1'b1, 3, 0, 1, 1'b1);
    do_restart();
    for (int i = 0; i < 10; i++) feed(1);
    cmp("sat_count", int'(sym_count), 7);
    cmp("sat_mismatch", int'(mismatch), 0);
    in_valid = 1'b1; in_sym = 1'b1; reset = 1'b1;
    tick();
    cmp("mid_rst_count", int'(sym_count), 0);
    cmp("mid_rst_out_a", int'(out_a), 0);
    cmp("mid_rst_out_b", int'(out_b), 0);
    cmp("mid_rst_idx", int'(mismatch_idx), 0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
